apb_master_bridge: RTL and testbench

//   APB requester stage directly upstream of the APB slave. Accepts single read/write

---
 rtl/apb_master_bridge.sv | 119 +++++++++++
 tb/tb_apb_master_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: one command at a time through IDLE -> SETUP -> ACCESS.
// Optional ACCESS wait-timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t              r_state;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                w_tmo;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait;

  // pready in the final wait cycle still completes normally
  assign w_tmo = !pready && (r_wait == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wait <= '0;
    end else if (r_state == S_SETUP) begin
      r_wait <= '0;
    end else if (r_state == S_ACCESS && !pready) begin
      r_wait <= r_wait + CW'(1);
    end
  end
`else
  // no wait counter: ACCESS waits for pready indefinitely
  assign w_tmo = (TIMEOUT_CYCLES < 1);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_addr      <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_pwrite  <= cmd_write;
            r_addr    <= cmd_addr;
            if (cmd_write) r_pwdata <= cmd_wdata;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready || w_tmo) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= pready ? pslverr : 1'b1;
            r_rsp_rdata <= (pready && !r_pwrite) ? prdata : '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign addr      = r_addr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed table, hand sequences, random traffic.
// The bench acts as the APB slave and keeps its own word-level memory model.
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  addr;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] smem [32];
  logic [31:0] mdl  [32];
  logic [31:0] last_wd;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_W(5),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .addr(addr), .pwdata(pwdata), .pready(pready),
    .pslverr(pslverr), .prdata(prdata)
  );

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    int          waits;
    logic        e;
    logic        h2;
    logic [31:0] er;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // slave answers this cycle based on what the bus currently shows
  task automatic slave_respond(input logic e);
    pready  = 1'b1;
    pslverr = e;
    prdata  = pwrite ? 32'hA5A5_5A5A : smem[addr];
    if (pwrite && !e) smem[addr] = pwdata;
  endtask

  task automatic do_xfer(input logic w, input logic [4:0] a,
                         input logic [31:0] d, input int waits,
                         input logic e, input logic h2,
                         input logic [31:0] er);
    logic [31:0] exp_pw;
    logic [31:0] exp_rd;
    exp_pw = w ? d : last_wd;
    exp_rd = w ? 32'h0 : er;
    chk1("idle_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 5'($urandom);
    cmd_wdata = $urandom;
    if (w) last_wd = d;
    chk1("setup_psel", psel, 1'b1);
    chk1("setup_penable", penable, 1'b0);
    chk1("setup_pwrite", pwrite, w);
    chk32("setup_addr", 32'(addr), 32'(a));
    chk32("setup_pwdata", pwdata, exp_pw);
    chk1("setup_ready", cmd_ready, 1'b0);
    chk1("setup_rsp", rsp_valid, 1'b0);
    tick();
    for (int i = 0; i <= waits; i++) begin
      chk1("acc_psel", psel, 1'b1);
      chk1("acc_penable", penable, 1'b1);
      chk32("acc_addr", 32'(addr), 32'(a));
      chk32("acc_pwdata", pwdata, exp_pw);
      chk1("acc_rsp", rsp_valid, 1'b0);
      if (i == waits) slave_respond(e);
      tick();
    end
    if (!h2) pready = 1'b0;
    chk1("done_rsp", rsp_valid, 1'b1);
    chk1("done_err", rsp_err, e);
    chk32("done_rdata", rsp_rdata, exp_rd);
    chk1("done_psel", psel, 1'b0);
    chk1("done_penable", penable, 1'b0);
    chk1("done_ready", cmd_ready, 1'b1);
    chk32("done_pwdata", pwdata, exp_pw);
    if (w && !e) mdl[a] = d;
    if (h2) begin
      tick();
      chk1("hold_rsp", rsp_valid, 1'b0);
      chk32("hold_rdata", rsp_rdata, exp_rd);
      chk1("hold_psel", psel, 1'b0);
    end
    pready  = 1'b0;
    pslverr = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'h03, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 5'h03, 32'h0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 5'h03, 32'h0, 0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 5'h1F, 32'h0000_0001, 3, 1'b0, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 5'h1F, 32'h0, 3, 1'b0, 1'b0, 32'h0000_0001};
    tbl[5] = '{1'b1, 5'h00, 32'h1234_5678, 2, 1'b1, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 5'h00, 32'h0, 0, 1'b0, 1'b0, 32'hC0DE_0000};

    for (int i = 0; i < 32; i++) begin
      smem[i] = 32'hC0DE_0000 | 32'(i);
      mdl[i]  = 32'hC0DE_0000 | 32'(i);
    end
    last_wd   = 32'h0;
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 5'h0;
    cmd_wdata = 32'h0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'h0;
    tick();
    tick();
    chk1("rst_psel", psel, 1'b0);
    chk1("rst_penable", penable, 1'b0);
    chk1("rst_pwrite", pwrite, 1'b0);
    chk32("rst_addr", 32'(addr), 32'h0);
    chk32("rst_pwdata", pwdata, 32'h0);
    chk1("rst_rsp", rsp_valid, 1'b0);
    chk32("rst_rdata", rsp_rdata, 32'h0);
    chk1("rst_err", rsp_err, 1'b0);
    resetn = 1'b1;
    tick();
    chk1("rst_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 7; i++)
      do_xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].waits,
              tbl[i].e, tbl[i].h2, tbl[i].er);

    // command held while busy: only taken once back in IDLE
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'h03;
    tick();
    cmd_write = 1'b1;
    cmd_addr  = 5'h07;
    cmd_wdata = 32'h0BAD_CAFE;
    chk1("hold_v_ready_s", cmd_ready, 1'b0);
    chk32("hold_v_addr_s", 32'(addr), 32'h03);
    chk1("hold_v_pwrite_s", pwrite, 1'b0);
    tick();
    chk1("hold_v_ready_a", cmd_ready, 1'b0);
    chk32("hold_v_addr_a", 32'(addr), 32'h03);
    chk1("hold_v_psel_a", psel, 1'b1);
    slave_respond(1'b0);
    tick();
    pready = 1'b0;
    chk1("hold_v_rsp", rsp_valid, 1'b1);
    chk32("hold_v_rdata", rsp_rdata, mdl[3]);
    chk1("hold_v_ready_i", cmd_ready, 1'b1);
    chk1("hold_v_psel_i", psel, 1'b0);
    tick();
    cmd_valid = 1'b0;
    last_wd   = 32'h0BAD_CAFE;
    chk1("hold_v_psel2", psel, 1'b1);
    chk32("hold_v_addr2", 32'(addr), 32'h07);
    chk1("hold_v_pwrite2", pwrite, 1'b1);
    chk32("hold_v_pwdata2", pwdata, 32'h0BAD_CAFE);
    chk1("hold_v_ready2", cmd_ready, 1'b0);
    tick();
    chk1("hold_v_pen2", penable, 1'b1);
    slave_respond(1'b0);
    tick();
    pready = 1'b0;
    chk1("hold_v_rsp2", rsp_valid, 1'b1);
    chk32("hold_v_rdata2", rsp_rdata, 32'h0);
    mdl[7] = 32'h0BAD_CAFE;

    // reset in the second ACCESS cycle drops the transfer
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'h05;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk1("mrst_pen", penable, 1'b1);
    tick();
    resetn  = 1'b0;
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'hFFFF_0000;
    tick();
    chk1("mrst_psel", psel, 1'b0);
    chk1("mrst_penable", penable, 1'b0);
    chk1("mrst_rsp", rsp_valid, 1'b0);
    chk1("mrst_ready", cmd_ready, 1'b1);
    chk32("mrst_pwdata", pwdata, 32'h0);
    resetn  = 1'b1;
    pready  = 1'b0;
    pslverr = 1'b0;
    last_wd = 32'h0;
    tick();
    chk1("mrst_rsp2", rsp_valid, 1'b0);
    chk1("mrst_psel2", psel, 1'b0);
    chk1("mrst_ready2", cmd_ready, 1'b1);

`ifdef APB_MASTER_TIMEOUT_EN
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'h04;
    prdata    = 32'h7777_7777;
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk1("tmo_psel", psel, 1'b1);
      chk1("tmo_rsp", rsp_valid, 1'b0);
    end
    tick();
    chk1("tmo_psel_end", psel, 1'b0);
    chk1("tmo_pen_end", penable, 1'b0);
    chk1("tmo_rsp_end", rsp_valid, 1'b1);
    chk1("tmo_err_end", rsp_err, 1'b1);
    chk32("tmo_rdata_end", rsp_rdata, 32'h0);
    tick();
    chk1("tmo_rsp_gone", rsp_valid, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic        w;
      logic [4:0]  a;
      logic [31:0] d;
      int          wt;
      logic        e;
      logic        h;
      w  = 1'($urandom);
      a  = 5'($urandom);
      d  = $urandom;
      wt = int'($urandom_range(3, 0));
      e  = ($urandom_range(7, 0) == 0);
      h  = 1'($urandom);
      do_xfer(w, a, d, wt, e, h, mdl[a]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
